pri_sel_rr_arb: RTL

PRI_SEL_RR_ARB -- requirements
Module: pri_sel_rr_arb

---
 rtl/pri_sel_pkg.sv | 12 +
 rtl/pri_sel_rr_arb_rr_pick.sv | 27 ++
 rtl/pri_sel_rr_arb.sv | 126 ++++++++++++
 3 files changed

// File: rtl/pri_sel_pkg.sv
// Shared types and default sizing for the priority-select round-robin arbiter.
package pri_sel_pkg;

    localparam int unsigned N_DEF = 4;
    localparam int unsigned P_DEF = 4;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/pri_sel_rr_arb_rr_pick.sv
// rr_pick: one-hot grant of the first set req bit at or above ptr, wrapping N-1 -> 0.
module rr_pick #(
    parameter int unsigned N = 4,
    localparam int unsigned NW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [NW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    // Walk upward from ptr with wrap and grant the first requester found.
    always_comb begin
        logic          found;
        logic [NW-1:0] idx;
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = NW'((32'(ptr) + k) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pri_sel_rr_arb.sv
// pri_sel_rr_arb: captures a per-input priority vector, finds the top level,
// and round-robin grants one input at that level with valid/accept hand-off.
// Optional macro PRI_SEL_LVL_PTR_EN: one round-robin pointer per priority level
// instead of a single shared pointer.
module pri_sel_rr_arb
    import pri_sel_pkg::*;
#(
    parameter int unsigned N  = N_DEF,
    parameter int unsigned P  = P_DEF,
    localparam int unsigned PW = $clog2(P),
    localparam int unsigned NW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [PW-1:0] pri_in [0:N-1],
    input  logic          in_valid,
    output logic          in_ready,
    output logic [PW-1:0] max_pri,
    output logic [N-1:0]  req_out,
    output logic [N-1:0]  gnt_out,
    output logic          gnt_valid,
    input  logic          gnt_accept
);

    state_t        state, state_nxt;
    logic          cap_c, acc_c;
    logic [PW-1:0] max_c;
    logic [N-1:0]  req_c, gnt_c;
    logic [NW-1:0] gidx_c, ptr_adv_c, ptr_sel_c;

`ifdef PRI_SEL_LVL_PTR_EN
    localparam int unsigned LVLS = 1 << PW;
    logic [NW-1:0] ptr_q [LVLS];
`else
    logic [NW-1:0] ptr_q;
`endif

    assign gnt_valid = (state == HOLD);
    assign in_ready  = (state == IDLE) || gnt_accept;
    assign cap_c     = in_valid && in_ready;
    assign acc_c     = gnt_valid && gnt_accept;

    // Highest priority present and the multi-hot set of inputs sitting at it.
    always_comb begin
        max_c = '0;
        req_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (pri_in[i] > max_c) max_c = pri_in[i];
        end
        for (int unsigned i = 0; i < N; i++) begin
            req_c[i] = (max_c != '0) && (pri_in[i] == max_c);
        end
    end

    // Pointer following the currently held winner, used when it is accepted.
    always_comb begin
        gidx_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt_out[i]) gidx_c = NW'(i);
        end
        ptr_adv_c = (32'(gidx_c) == N - 1) ? '0 : NW'(32'(gidx_c) + 1);
    end

    // A capture coinciding with an accept searches from the already-advanced pointer.
    always_comb begin
`ifdef PRI_SEL_LVL_PTR_EN
        ptr_sel_c = (acc_c && (max_pri == max_c)) ? ptr_adv_c : ptr_q[max_c];
`else
        ptr_sel_c = acc_c ? ptr_adv_c : ptr_q;
`endif
    end

    rr_pick #(.N(N)) u_rr_pick (
        .req (req_c),
        .ptr (ptr_sel_c),
        .gnt (gnt_c)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next state: only a non-zero capture produces a grant.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (cap_c && (max_c != '0)) state_nxt = HOLD;
            HOLD: if (gnt_accept) state_nxt = (cap_c && (max_c != '0)) ? HOLD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Result registers: load on capture, clear once a grant is consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_pri <= '0;
            req_out <= '0;
            gnt_out <= '0;
        end else if (cap_c) begin
            max_pri <= max_c;
            req_out <= req_c;
            gnt_out <= gnt_c;
        end else if (acc_c) begin
            max_pri <= '0;
            req_out <= '0;
            gnt_out <= '0;
        end
    end

    // Round-robin pointer(s): move only when a presented grant is accepted.
    always_ff @(posedge clk or posedge rst) begin
`ifdef PRI_SEL_LVL_PTR_EN
        if (rst) begin
            for (int unsigned l = 0; l < LVLS; l++) ptr_q[l] <= '0;
        end else if (acc_c) begin
            ptr_q[max_pri] <= ptr_adv_c;
        end
`else
        if (rst)        ptr_q <= '0;
        else if (acc_c) ptr_q <= ptr_adv_c;
`endif
    end

endmodule
